// File: rtl/cjb_mmio_pkg.sv
// Shared constants for the cjbRISC memory-mapped I/O port: register offsets
// within the decode window and control-register bit positions.
package cjb_mmio_pkg;

  localparam int NUM_REGS = 5;
  localparam int OFF_W    = 3;

  typedef enum logic [OFF_W-1:0] {
    OFF_SW      = 3'd0,
    OFF_BTN_LVL = 3'd1,
    OFF_BTN_EVT = 3'd2,
    OFF_LED     = 3'd3,
    OFF_CTRL    = 3'd4
  } reg_off_e;

  localparam int IRQ_EN = 0;

endpackage

// File: rtl/cjb_debounce.sv
// One pushbutton: 2-flop synchroniser followed by a consecutive-sample
// debounce counter. Flags a press on the edge the stable level falls.
module cjb_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic stable,
  output logic press
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             meta_reg;
  logic             sync_reg;
  logic             stable_reg;
  logic             stable_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             accept;

  // Buttons idle high, so every flop in the chain resets to 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg   <= 1'b1;
      sync_reg   <= 1'b1;
      stable_reg <= 1'b1;
      cnt_reg    <= '0;
    end else begin
      meta_reg   <= raw;
      sync_reg   <= meta_reg;
      stable_reg <= stable_next;
      cnt_reg    <= cnt_next;
    end
  end

  always_comb begin
    accept      = (sync_reg != stable_reg) && (cnt_reg == CNT_LAST);
    stable_next = stable_reg;
    cnt_next    = '0;
    if (sync_reg != stable_reg) begin
      if (accept) begin
        stable_next = sync_reg;
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end
  end

  assign stable = stable_reg;
  assign press  = accept & ~sync_reg;

endmodule

// File: rtl/cjb_mmio_port.sv
// Memory-mapped switch / pushbutton / LED peripheral with sticky press
// events and a maskable level interrupt, decoded at BASE_ADDR..BASE_ADDR+4.
module cjb_mmio_port
  import cjb_mmio_pkg::*;
#(
  parameter int               DATA_W     = 16,
  parameter int               ADDR_W     = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 8'hF0,
  parameter int               N_SW       = 4,
  parameter int               N_BTN      = 1,
  parameter int               N_LED      = 8,
  parameter int               DEB_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              we,
  input  logic              re,
  output logic [DATA_W-1:0] rd_data,
  input  logic [N_SW-1:0]   sw,
  input  logic [N_BTN-1:0]  pb,
  output logic [N_LED-1:0]  leds,
  output logic              irq
);

  logic [N_SW-1:0]   sw_meta_reg;
  logic [N_SW-1:0]   sw_sync_reg;
  logic [N_BTN-1:0]  btn_stable;
  logic [N_BTN-1:0]  btn_press;
  logic [N_BTN-1:0]  evt_reg;
  logic [N_BTN-1:0]  evt_next;
  logic [N_BTN-1:0]  clr_mask;
  logic [N_LED-1:0]  led_reg;
  logic              irq_en_reg;
  logic              irq_reg;
  logic [DATA_W-1:0] rd_data_reg;
  logic [DATA_W-1:0] rd_word;

  logic [ADDR_W-1:0] offset;
  logic [OFF_W-1:0]  reg_idx;
  logic              hit;
  logic              wr_sel;
  logic              unused_bits;

  // Compare one bit wider so a window near the top of the map cannot wrap.
  assign offset  = addr - BASE_ADDR;
  assign reg_idx = offset[OFF_W-1:0];
  assign hit     = ({1'b0, addr} >= {1'b0, BASE_ADDR}) &&
                   ({1'b0, addr} <  ({1'b0, BASE_ADDR} + (ADDR_W+1)'(NUM_REGS)));
  assign wr_sel  = we & hit;

  assign unused_bits = ^{wr_data, offset};

  generate
    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
      cjb_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
      ) u_debounce (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (pb[gi]),
        .stable(btn_stable[gi]),
        .press (btn_press[gi])
      );
    end
  endgenerate

  always_comb begin
    rd_word = '0;
    if (hit) begin
      case (reg_off_e'(reg_idx))
        OFF_SW:      rd_word[N_SW-1:0]  = sw_sync_reg;
        OFF_BTN_LVL: rd_word[N_BTN-1:0] = ~btn_stable;
        OFF_BTN_EVT: rd_word[N_BTN-1:0] = evt_reg;
        OFF_LED:     rd_word[N_LED-1:0] = led_reg;
        OFF_CTRL:    rd_word[IRQ_EN]    = irq_en_reg;
        default:     rd_word            = '0;
      endcase
    end
  end

  // A new press beats a same-cycle write-1-to-clear.
  always_comb begin
    clr_mask = '0;
    if (wr_sel && (reg_idx == OFF_BTN_EVT)) begin
      clr_mask = wr_data[N_BTN-1:0];
    end
    evt_next = (evt_reg & ~clr_mask) | btn_press;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta_reg <= '0;
      sw_sync_reg <= '0;
      evt_reg     <= '0;
      led_reg     <= '0;
      irq_en_reg  <= 1'b0;
      irq_reg     <= 1'b0;
      rd_data_reg <= '0;
    end else begin
      sw_meta_reg <= sw;
      sw_sync_reg <= sw_meta_reg;
      evt_reg     <= evt_next;
      irq_reg     <= irq_en_reg & (|evt_reg);
      if (wr_sel && (reg_idx == OFF_LED)) begin
        led_reg <= wr_data[N_LED-1:0];
      end
      if (wr_sel && (reg_idx == OFF_CTRL)) begin
        irq_en_reg <= wr_data[IRQ_EN];
      end
      if (re) begin
        rd_data_reg <= rd_word;
      end
    end
  end

  assign rd_data = rd_data_reg;
  assign leds    = led_reg;
  assign irq     = irq_reg;

endmodule

// File: tb/tb_cjb_mmio_port.sv
// Directed bench for cjb_mmio_port: a window-based behavioural model is
// compared against the DUT every cycle, plus hand-computed spot values.
module tb_cjb_mmio_port;

  localparam int DEB = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  addr;
  logic [15:0] wr_data;
  logic        we;
  logic        re;
  logic [15:0] rd_data;
  logic [3:0]  sw;
  logic [0:0]  pb;
  logic [7:0]  leds;
  logic        irq;

  int n_checks = 0;
  int n_pass   = 0;
  logic chk_en = 1'b0;

  // Model state
  logic [3:0]  m_sw1, m_sw2;
  logic        m_pb1, m_pb2;
  logic        m_stable;
  logic        m_win [DEB];
  logic        m_evt, m_ctrl, m_irq;
  logic [7:0]  m_leds;
  logic [15:0] m_rd;

  cjb_mmio_port dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .addr   (addr),
    .wr_data(wr_data),
    .we     (we),
    .re     (re),
    .rd_data(rd_data),
    .sw     (sw),
    .pb     (pb),
    .leds   (leds),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic model_reset();
    m_sw1 = '0; m_sw2 = '0;
    m_pb1 = 1'b1; m_pb2 = 1'b1; m_stable = 1'b1;
    for (int i = 0; i < DEB; i++) m_win[i] = 1'b1;
    m_evt = 1'b0; m_ctrl = 1'b0; m_irq = 1'b0;
    m_leds = '0; m_rd = '0;
  endtask

  // One rising edge worth of behaviour, computed from the register-map rules.
  task automatic model_step();
    int a, idx;
    logic hit, all_diff, accept, pressv, clr, n_stable;
    logic [15:0] rv;
    if (!rst_n) begin
      model_reset();
      return;
    end
    a   = int'(addr);
    hit = (a >= 'hF0) && (a <= 'hF4);
    idx = a - 'hF0;
    rv  = '0;
    if (hit) begin
      case (idx)
        0: rv = {12'b0, m_sw2};
        1: rv = {15'b0, ~m_stable};
        2: rv = {15'b0, m_evt};
        3: rv = {8'b0, m_leds};
        4: rv = {15'b0, m_ctrl};
        default: rv = '0;
      endcase
    end
    // Accept a new level once DEB consecutive synchronised samples disagree.
    for (int i = DEB - 1; i > 0; i--) m_win[i] = m_win[i-1];
    m_win[0] = m_pb2;
    all_diff = 1'b1;
    for (int i = 0; i < DEB; i++) if (m_win[i] == m_stable) all_diff = 1'b0;
    accept   = all_diff;
    n_stable = accept ? ~m_stable : m_stable;
    pressv   = accept && (n_stable == 1'b0);
    clr      = we && hit && (idx == 2) && wr_data[0];

    m_irq    = m_ctrl & m_evt;
    m_evt    = (m_evt & ~clr) | pressv;
    m_stable = n_stable;
    if (we && hit && idx == 3) m_leds = wr_data[7:0];
    if (we && hit && idx == 4) m_ctrl = wr_data[0];
    if (re) m_rd = rv;
    m_sw2 = m_sw1; m_sw1 = sw;
    m_pb2 = m_pb1; m_pb1 = pb[0];
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("leds", {24'b0, leds}, {24'b0, m_leds});
      check("irq", {31'b0, irq}, {31'b0, m_irq});
      check("rd_data", {16'b0, rd_data}, {16'b0, m_rd});
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle(input int n);
    we = 1'b0; re = 1'b0;
    repeat (n) tick();
  endtask

  task automatic wr(input logic [7:0] a, input logic [15:0] d);
    addr = a; wr_data = d; we = 1'b1; re = 1'b0;
    tick();
    we = 1'b0;
    $display("WR addr=%02h data=%04h leds=%02h irq=%0b", a, d, leds, irq);
  endtask

  task automatic rd(input logic [7:0] a, input logic [15:0] exp, input string name);
    addr = a; re = 1'b1; we = 1'b0;
    tick();
    re = 1'b0;
    $display("RD addr=%02h data=%04h", a, rd_data);
    check(name, {16'b0, rd_data}, {16'b0, exp});
  endtask

  initial begin
    rst_n = 1'b0; addr = '0; wr_data = '0; we = 1'b0; re = 1'b0;
    sw = 4'b1010; pb = 1'b1;
    model_reset();

    tick();
    chk_en = 1'b1;
    repeat (4) tick();
    check("rst_leds", {24'b0, leds}, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    check("rst_rd", {16'b0, rd_data}, 32'h0);
    rst_n = 1'b1;
    idle(3);
    rd(8'hF0, 16'h000A, "sw_data");

    wr(8'hF3, 16'hA5A5);
    check("led_write", {24'b0, leds}, 32'hA5);
    rd(8'hF3, 16'h00A5, "led_readback");

    // 3-cycle glitch must be rejected
    pb = 1'b0; idle(3); pb = 1'b1; idle(8);
    rd(8'hF1, 16'h0000, "glitch_lvl");
    rd(8'hF2, 16'h0000, "glitch_evt");

    // Held press: level visible on edge 6 after the pin change
    pb = 1'b0; idle(5);
    rd(8'hF1, 16'h0000, "lvl_edge6_old");
    rd(8'hF1, 16'h0001, "lvl_edge7");
    rd(8'hF2, 16'h0001, "evt_set");

    check("irq_masked", {31'b0, irq}, 32'h0);
    wr(8'hF4, 16'h0001);
    check("irq_lag", {31'b0, irq}, 32'h0);
    idle(1);
    check("irq_rise", {31'b0, irq}, 32'h1);
    wr(8'hF2, 16'h0001);
    check("irq_hold", {31'b0, irq}, 32'h1);
    idle(1);
    check("irq_fall", {31'b0, irq}, 32'h0);
    rd(8'hF2, 16'h0000, "evt_cleared");

    pb = 1'b1; idle(8);
    rd(8'hF2, 16'h0000, "release_no_evt");
    rd(8'hF1, 16'h0000, "lvl_released");

    // Clear lands on the same edge as a new press
    pb = 1'b0; idle(5);
    wr(8'hF2, 16'h0001);
    rd(8'hF2, 16'h0001, "set_wins");

    wr(8'hEF, 16'hFFFF);
    wr(8'hF5, 16'hFFFF);
    rd(8'hF5, 16'h0000, "miss_read");
    check("miss_leds", {24'b0, leds}, 32'hA5);
    rd(8'hF4, 16'h0001, "ctrl_kept");
    rd(8'hF2, 16'h0001, "evt_kept");

    // Read and write together return the pre-write value
    addr = 8'hF3; wr_data = 16'h003C; we = 1'b1; re = 1'b1;
    tick();
    we = 1'b0; re = 1'b0;
    $display("RW addr=F3 data=003C rd=%04h leds=%02h", rd_data, leds);
    check("rw_pre_value", {16'b0, rd_data}, 32'h00A5);
    check("rw_leds", {24'b0, leds}, 32'h3C);

    // Async reset in the middle of a press count
    pb = 1'b1; idle(8);
    check("irq_before_rst", {31'b0, irq}, 32'h1);
    pb = 1'b0; idle(3);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("arst_leds", {24'b0, leds}, 32'h0);
    check("arst_irq", {31'b0, irq}, 32'h0);
    check("arst_rd", {16'b0, rd_data}, 32'h0);
    idle(2);
    rst_n = 1'b1;
    rd(8'hF2, 16'h0000, "evt_after_rst");
    idle(4);
    rd(8'hF1, 16'h0000, "fresh_edge6_old");
    rd(8'hF1, 16'h0001, "fresh_edge7");
    rd(8'hF2, 16'h0001, "fresh_evt");
    check("irq_ctrl_rst", {31'b0, irq}, 32'h0);
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cjb_mmio_port.md
Name: cjb_mmio_port

Overview:
Parametrised memory-mapped I/O peripheral for the cjbRISC HMMIOP processor. It generalises the fixed 4-switch / 1-pushbutton / 8-LED I/O to configurable channel counts and widths. It adds input synchronisation, per-button debounce, sticky press-event capture and a maskable interrupt. It sits on the processor data-memory bus and claims a small window of word addresses starting at BASE_ADDR.

Parameters:
DATA_W, 16, data bus width (bits)
ADDR_W, 8, word address width
BASE_ADDR, 8'hF0, first word address of the 5-register window
N_SW, 4, number of slide-switch inputs (must be <= DATA_W)
N_BTN, 1, number of pushbuttons (active-low, idle 1; must be <= DATA_W)
N_LED, 8, number of LED outputs (must be <= DATA_W)
DEB_CYCLES, 4, consecutive stable samples required to accept a button change (>= 2)

Ports:
Clock  in  1  system clock; all state updates on the rising edge
Reset  in  1  asynchronous, active-low reset
Addr  in  ADDR_W  bus word address
WrData  in  DATA_W  bus write data
WE  in  1  write strobe, one cycle per access
RE  in  1  read strobe, one cycle per access
RdData  out  DATA_W  registered read data
SW  in  N_SW  raw switch pins
PB  in  N_BTN  raw pushbutton pins, active-low
LEDs  out  N_LED  LED drive register
IRQ  out  1  level interrupt request

Behaviour:
- Reset (Reset=0, asynchronous): RdData=0, LEDs=0, IRQ=0, event latch=0, IRQ enable=0.
  - Synchronisers and debounced state reset to the idle pin level: SW sync=0, PB sync and PB stable=all 1s.
  - Debounce counters=0.
  - Release is synchronous to Clock. Reset asserted mid-access aborts that access; no partial write.
- Register map, as word offsets from BASE_ADDR; unused upper bits read 0:
  - 0 SW_DATA (RO): synchronised SW.
  - 1 BTN_LEVEL (RO): debounced pressed state = ~stable PB.
  - 2 BTN_EVT (RW1C): sticky press events.
  - 3 LED (RW): low N_LED bits of WrData.
  - 4 CTRL (RW): bit0 = IRQ enable.
- Decode: hit when BASE_ADDR <= Addr <= BASE_ADDR+4.
  - Miss on write: ignored.
  - Miss on read: RdData=0.
  - WE and RE together at one address: the read returns the pre-write value.
- Read latency: RdData is valid 1 cycle after RE and holds until the next RE or reset.
- Write latency: the register updates on the WE edge. LEDs reflect the write the same edge.
- SW and PB inputs each pass through a 2-flop synchroniser.
- Debounce, per button:
  - While sync != stable, the counter increments.
  - When the counter = DEB_CYCLES-1 and sync still != stable: stable <= sync and the counter clears.
  - Any cycle with sync == stable clears the counter.
  - A pin change is therefore visible in BTN_LEVEL 2+DEB_CYCLES cycles after it reaches the pin.
  - Glitches shorter than DEB_CYCLES cycles are rejected.
  - The counter is $clog2(DEB_CYCLES) bits and never wraps.
- Event capture:
  - A stable 1->0 transition (a press) sets BTN_EVT[i] on the same edge that updates stable.
  - Releases set nothing.
  - Writing 1 to bit i clears it; writing 0 leaves it unchanged.
  - A set and a clear on the same cycle leave the bit set (set wins).
- IRQ = CTRL[0] & |BTN_EVT, registered, so it lags the event/enable change by 1 cycle.

Decomposition:
- Shared package cjb_mmio_pkg:
  - Register offset constants: OFF_SW=0, OFF_BTN_LVL=1, OFF_BTN_EVT=2, OFF_LED=3, OFF_CTRL=4.
  - NUM_REGS=5.
  - CTRL bit index IRQ_EN=0.
- Sub-module cjb_debounce: one button.
  - Ports: Clock, Reset, raw in, stable out, press pulse out.
  - Contains the synchroniser and counter; parameter DEB_CYCLES.
  - Instantiated N_BTN times via generate.

Test Plan:
- Reset: hold Reset=0 for 5 cycles with PB=1, SW=4'b1010 -> LEDs=0, IRQ=0, RdData=0. After release, a read at 0xF0 returns 16'h000A 1 cycle after RE.
- LED write/readback: WE at 0xF3 with 16'hA5A5 -> LEDs=8'hA5 on that edge. A read at 0xF3 returns 16'h00A5.
- Debounce, DEB_CYCLES=4:
  - PB=0 for 3 cycles, then 1 -> BTN_LEVEL stays 0 and BTN_EVT stays 0.
  - PB=0 held -> BTN_LEVEL=1 and BTN_EVT[0]=1 exactly 6 cycles after the pin change.
- IRQ and RW1C:
  - With an event pending, write 0xF4=1 -> IRQ=1 the next cycle.
  - Write 0xF2=1 -> the bit clears and IRQ falls 1 cycle later.
  - A clear write landing on the same cycle as a new press leaves BTN_EVT[0]=1.
- Out-of-window: write 16'hFFFF to 0xEF and 0xF5 -> no register changes; a read at 0xF5 returns 0.
- Async reset mid-operation: assert Reset between clock edges during a pending press count -> outputs clear immediately and the counter returns to 0; no event after release until a fresh full-length press.
